sample_capture_buffer: RTL and testbench

Parametrised successor to the single-word sample buffer. It accepts wide packed words of `SAMPLE_W`-bit samples through a valid/ready handshake, unpacks the first `in_count` samples at one sample per cycle, and writes them into a `DEPTH`-entry RAM. Capture runs in one of two modes: one-shot (stop when full) or circular (keep overwriting until stopped). A synchronous read port returns the captured samples in chronological order, oldest first, for the downstream processing stage.

---
 rtl/sample_capture_pkg.sv | 23 ++
 rtl/sample_capture_ram.sv | 27 ++
 rtl/sample_capture_buffer.sv | 174 +++++++++++++++++
 tb/tb_sample_capture_buffer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_capture_pkg.sv
// Shared types and width helpers for the sample capture buffer.
package sample_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_UNPACK,
        ST_DONE
    } state_e;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sample_capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module sample_capture_ram #(
    parameter int SAMPLE_W = 24,
    parameter int DEPTH    = 3750,
    parameter int ADDR_W   = 12
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [SAMPLE_W-1:0] wdata,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [SAMPLE_W-1:0] rdata
);

    logic [SAMPLE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sample_capture_buffer.sv
// Captures unpacked samples into a RAM in one-shot or circular mode and
// serves them back oldest-first through a registered read port.
module sample_capture_buffer
    import sample_capture_pkg::*;
#(
    parameter int SAMPLE_W = 24,
    parameter int LANES    = 32,
    parameter int DEPTH    = 3750
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*SAMPLE_W-1:0]   in_data,
    input  logic [cnt_w(LANES)-1:0]     in_count,
    input  logic                        arm,
    input  logic                        stop,
    input  logic                        mode,
    output logic                        acquired,
    output logic                        overflow,
    output logic [lvl_w(DEPTH)-1:0]     fill_level,
    input  logic [ptr_w(DEPTH)-1:0]     rd_addr,
    input  logic                        rd_en,
    output logic [SAMPLE_W-1:0]         rd_data,
    output logic                        rd_valid
);

    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int CNT_W  = cnt_w(LANES);
    localparam int LVL_W  = lvl_w(DEPTH);
    localparam int SUM_W  = PTR_W + 1;
    localparam int WORD_W = LANES * SAMPLE_W;

    state_e state_q, state_d;

    logic [WORD_W-1:0] word_q;
    logic [CNT_W-1:0]  rem_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [LVL_W-1:0]  fill_q;
    logic              wrapped_q;
    logic              mode_q;
    logic              overflow_q;
    logic              stop_pend_q;
    logic              rd_valid_q;

    logic [CNT_W-1:0]  cnt_clamp;
    logic              idle_or_done;
    logic              accept;
    logic              load;
    logic              wr_en;
    logic              last_wr;
    logic              full_wr;
    logic [LVL_W-1:0]  fill_inc;
    logic [PTR_W-1:0]  ptr_inc;
    logic [SUM_W-1:0]  addr_sum;
    logic [SUM_W-1:0]  addr_mod;
    logic [PTR_W-1:0]  phys_addr;
    logic              rd_ok;
    logic [SAMPLE_W-1:0] ram_q;

    always_comb begin
        cnt_clamp    = (in_count > CNT_W'(LANES)) ? CNT_W'(LANES) : in_count;
        idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
        accept       = (state_q == ST_CAPTURE) && in_valid;
        load         = accept && (cnt_clamp != '0);
        wr_en        = (state_q == ST_UNPACK);
        last_wr      = wr_en && (rem_q == CNT_W'(1));
        fill_inc     = (fill_q == LVL_W'(DEPTH)) ? fill_q : fill_q + LVL_W'(1);
        full_wr      = wr_en && !mode_q && (fill_inc == LVL_W'(DEPTH));
        ptr_inc      = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0
                                                       : wr_ptr_q + PTR_W'(1);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (load)      state_d = ST_UNPACK;
                else if (stop) state_d = ST_DONE;
            end
            ST_UNPACK: begin
                if (full_wr) begin
                    state_d = ST_DONE;
                end else if (last_wr) begin
                    state_d = (stop_pend_q || stop) ? ST_DONE : ST_CAPTURE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q      <= '0;
            rem_q       <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            wrapped_q   <= 1'b0;
            mode_q      <= 1'b0;
            overflow_q  <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            if (idle_or_done && arm) begin
                wr_ptr_q    <= '0;
                fill_q      <= '0;
                wrapped_q   <= 1'b0;
                overflow_q  <= 1'b0;
                stop_pend_q <= 1'b0;
                mode_q      <= mode;
            end
            if (load) begin
                word_q <= in_data;
                rem_q  <= cnt_clamp;
                if (stop) stop_pend_q <= 1'b1;
            end
            // Word is shifted so the next sample always sits in the MSB lane.
            if (wr_en) begin
                word_q   <= word_q << SAMPLE_W;
                rem_q    <= rem_q - CNT_W'(1);
                wr_ptr_q <= ptr_inc;
                fill_q   <= fill_inc;
                if (mode_q && (wr_ptr_q == PTR_W'(DEPTH - 1))) wrapped_q <= 1'b1;
                if (stop) stop_pend_q <= 1'b1;
                if (full_wr && !last_wr) overflow_q <= 1'b1;
            end
            if (state_d == ST_DONE) stop_pend_q <= 1'b0;
        end
    end

    // Logical index to physical slot: oldest entry sits at wr_ptr once wrapped.
    always_comb begin
        addr_sum  = {1'b0, wr_ptr_q} + {1'b0, rd_addr};
        addr_mod  = (addr_sum >= SUM_W'(DEPTH)) ? addr_sum - SUM_W'(DEPTH)
                                                : addr_sum;
        phys_addr = wrapped_q ? addr_mod[PTR_W-1:0] : rd_addr;
        rd_ok     = rd_en && (state_q == ST_DONE)
                    && (LVL_W'(rd_addr) < fill_q);
    end

    always_ff @(posedge clk) begin
        if (reset) rd_valid_q <= 1'b0;
        else       rd_valid_q <= rd_ok;
    end

    sample_capture_ram #(
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (word_q[WORD_W-1 -: SAMPLE_W]),
        .re    (rd_ok),
        .raddr (phys_addr),
        .rdata (ram_q)
    );

    assign in_ready   = (state_q == ST_CAPTURE);
    assign acquired   = (state_q == ST_DONE);
    assign overflow   = overflow_q;
    assign fill_level = fill_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_valid_q ? ram_q : '0;

endmodule

// File: tb/tb_sample_capture_buffer.sv
// Directed bench for sample_capture_buffer with a queue-based reference model.
module tb_sample_capture_buffer;

    localparam int SW = 24;
    localparam int LN = 4;
    localparam int DP = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [LN*SW-1:0] in_data = '0;
    logic [2:0]      in_count = '0;
    logic            arm = 1'b0;
    logic            stop = 1'b0;
    logic            mode = 1'b0;
    logic            acquired;
    logic            overflow;
    logic [3:0]      fill_level;
    logic [3:0]      rd_addr = '0;
    logic            rd_en = 1'b0;
    logic [SW-1:0]   rd_data;
    logic            rd_valid;

    sample_capture_buffer #(
        .SAMPLE_W (SW),
        .LANES    (LN),
        .DEPTH    (DP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_count   (in_count),
        .arm        (arm),
        .stop       (stop),
        .mode       (mode),
        .acquired   (acquired),
        .overflow   (overflow),
        .fill_level (fill_level),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit started = 1'b0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    // Reference model: pending samples of the current word and the retained history.
    bit m_cap, m_done, m_mode, m_ovf, m_pstop, m_rdv;
    int m_rdd;
    int pend[$];
    int hist[$];
    bit rv;
    int rdd, n;

    task automatic finish_cap();
        m_cap = 1'b0;
        m_done = 1'b1;
        m_pstop = 1'b0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_cap = 0; m_done = 0; m_mode = 0; m_ovf = 0; m_pstop = 0;
            m_rdv = 0; m_rdd = 0;
            pend.delete();
            hist.delete();
        end else begin
            rv = rd_en && m_done && (int'(rd_addr) < hist.size());
            rdd = rv ? hist[rd_addr] : 0;
            if (!m_cap) begin
                if (arm) begin
                    hist.delete(); pend.delete();
                    m_ovf = 0; m_pstop = 0; m_done = 0;
                    m_cap = 1; m_mode = mode;
                end
            end else if (pend.size() > 0) begin
                hist.push_back(pend.pop_front());
                if (m_mode && hist.size() > DP) void'(hist.pop_front());
                if (stop) m_pstop = 1;
                if (!m_mode && hist.size() == DP) begin
                    if (pend.size() > 0) m_ovf = 1;
                    pend.delete();
                    finish_cap();
                end else if (pend.size() == 0 && m_pstop) begin
                    finish_cap();
                end
            end else if (in_valid) begin
                n = (int'(in_count) > LN) ? LN : int'(in_count);
                for (int k = 0; k < n; k++) pend.push_back(int'(in_data[(LN-1-k)*SW +: SW]));
                if (stop) begin
                    if (n == 0) finish_cap();
                    else m_pstop = 1;
                end
            end else if (stop) begin
                finish_cap();
            end
            m_rdv = rv;
            m_rdd = rdd;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", in_ready, m_cap && pend.size() == 0);
            chk("acquired", acquired, m_done);
            chk("overflow", overflow, m_ovf);
            chk("fill_level", fill_level, hist.size());
            chk("rd_valid", rd_valid, m_rdv);
            if (m_rdv) chk("rd_data", rd_data, m_rdd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic arm_cap(input bit m);
        arm = 1; mode = m;
        tick();
        arm = 0; mode = 0;
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!in_ready && g < 40) begin tick(); g++; end
        if (!in_ready) chk("ready_timeout", in_ready, 1);
    endtask

    task automatic wait_acq();
        int g = 0;
        while (!acquired && g < 40) begin tick(); g++; end
        if (!acquired) chk("acq_timeout", acquired, 1);
    endtask

    task automatic send(input logic [SW-1:0] a, input logic [SW-1:0] b,
                        input logic [SW-1:0] c, input logic [SW-1:0] d,
                        input int cnt, input bit st);
        wait_ready();
        in_data = {a, b, c, d};
        in_count = 3'(cnt);
        in_valid = 1; stop = st;
        tick();
        in_valid = 0; stop = 0;
    endtask

    task automatic do_stop();
        stop = 1;
        tick();
        stop = 0;
    endtask

    task automatic rd_chk(input int addr, input int exp);
        rd_addr = 4'(addr); rd_en = 1;
        tick();
        rd_en = 0;
        chk("rd_valid_lit", rd_valid, 1);
        chk("rd_data_lit", rd_data, exp);
    endtask

    task automatic count_low(input string nm, input int exp);
        int low = 0;
        while (!in_ready && low < 20) begin low++; tick(); end
        chk(nm, low, exp);
    endtask

    initial begin
        tick(); tick();
        started = 1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_acquired", acquired, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        reset = 0;
        tick();

        // one-shot fill with overflow
        arm_cap(0);
        chk("arm_ready", in_ready, 1);
        send(1, 2, 3, 4, 4, 0);
        send(5, 6, 7, 8, 4, 0);
        send(9, 10, 11, 12, 4, 0);
        wait_acq();
        chk("os_fill", fill_level, 10);
        chk("os_ovf", overflow, 1);
        for (int i = 0; i < DP; i++) rd_chk(i, i + 1);

        // partial counts, zero-count word, clamp
        arm_cap(0);
        send(1, 2, 77, 88, 2, 0);
        count_low("stall_cnt2", 2);
        send(55, 56, 57, 58, 0, 0);
        chk("no_stall_cnt0", in_ready, 1);
        send(3, 4, 5, 6, 5, 0);
        count_low("stall_cnt5", 4);
        do_stop();
        chk("pc_acq", acquired, 1);
        chk("pc_fill", fill_level, 6);
        chk("pc_ovf", overflow, 0);
        rd_addr = 7; rd_en = 1;
        tick();
        rd_en = 0;
        chk("guard_addr", rd_valid, 0);
        rd_chk(5, 6);
        tick();
        chk("rd_one_cycle", rd_valid, 0);

        // circular wrap
        arm_cap(1);
        send(1, 2, 3, 4, 4, 0);
        send(5, 6, 7, 8, 4, 0);
        send(9, 10, 11, 12, 4, 0);
        send(13, 0, 0, 0, 1, 0);
        wait_ready();
        rd_addr = 0; rd_en = 1;
        tick();
        rd_en = 0;
        chk("guard_capture", rd_valid, 0);
        do_stop();
        chk("cw_fill", fill_level, 10);
        chk("cw_ovf", overflow, 0);
        for (int i = 0; i < DP; i++) rd_chk(i, i + 4);

        // stop coincident with an accepted word
        arm_cap(0);
        send(21, 22, 23, 24, 4, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("cs_acq_low", acquired, 0);
        end
        tick();
        chk("cs_acq_high", acquired, 1);
        chk("cs_fill", fill_level, 4);
        rd_chk(3, 24);

        // reset in the second unpack cycle
        arm_cap(1);
        send(41, 42, 43, 44, 4, 0);
        tick();
        reset = 1;
        tick();
        reset = 0;
        chk("mr_in_ready", in_ready, 0);
        chk("mr_acquired", acquired, 0);
        chk("mr_overflow", overflow, 0);
        chk("mr_fill", fill_level, 0);
        chk("mr_rd_valid", rd_valid, 0);
        chk("mr_rd_data", rd_data, 0);
        arm_cap(0);
        send(31, 32, 33, 34, 4, 0);
        wait_ready();
        do_stop();
        chk("mr2_fill", fill_level, 4);
        rd_chk(0, 31);
        rd_chk(3, 34);

        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
